// File: rtl/fsm_seq_pkg.sv
// Shared encodings and the golden next-state/output function for the
// 5-state serial Mealy recognizer and its driver controller.
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    GS_A = 3'b000,
    GS_B = 3'b001,
    GS_D = 3'b010,
    GS_F = 3'b011,
    GS_G = 3'b100
  } gst_e;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_RST   = 3'd1,
    C_DRIVE = 3'd2,
    C_DRAIN = 3'd3,
    C_DONE  = 3'd4
  } cst_e;

  typedef struct packed {
    logic [2:0] ns;
    logic       y;
  } gstep_t;

  // One step of the recognizer: next state and y for input x.
  // Unused encodings fall back to A with y=0.
  function automatic gstep_t golden_step(input logic [2:0] s, input logic x);
    gstep_t r;
    r.ns = GS_A;
    r.y  = 1'b0;
    case (s)
      GS_A: begin r.ns = x ? GS_B : GS_F; r.y = 1'b0; end
      GS_B: begin r.ns = x ? GS_A : GS_D; r.y = 1'b0; end
      GS_D: begin r.ns = x ? GS_A : GS_G; r.y = ~x;   end
      GS_F: begin r.ns = x ? GS_B : GS_F; r.y = 1'b1; end
      GS_G: begin r.ns = x ? GS_D : GS_G; r.y = x;    end
      default: begin r.ns = GS_A; r.y = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsm_seq_driver_golden_model.sv
// Golden copy of the recognizer; y is registered together with the state.
module fsm_golden_model
  import fsm_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       x_i,
  output logic [2:0] state_o,
  output logic       y_o
);

  logic [2:0] state_q;
  logic       y_q;
  gstep_t     step;

  assign step = golden_step(state_q, x_i);

  // State/y register: sync clear wins over enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= GS_A;
      y_q     <= 1'b0;
    end else if (clr_i) begin
      state_q <= GS_A;
      y_q     <= 1'b0;
    end else if (en_i) begin
      state_q <= step.ns;
      y_q     <= step.y;
    end
  end

  assign state_o = state_q;
  assign y_o     = y_q;

endmodule

// File: rtl/fsm_seq_driver.sv
// Front-end for the serial recognizer: resets it, shifts a pattern in
// MSB-first, captures the returned y stream and compares it against a
// golden copy of the machine.
module fsm_seq_driver
  import fsm_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             x_out,
  output logic             dut_reset_n,
  input  logic             y_in,
  output logic [WIDTH-1:0] y_word,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             pass,
  output logic [2:0]       model_state
);

  cst_e             state_q, state_d;
  logic [WIDTH-1:0] sh_q;
  logic             x_q;
  logic             drst_q;
  logic [CNT_W-1:0] idx_q;
  logic             smp_q;    // a y sample is due on this edge
  logic [WIDTH-1:0] yw_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q;
  logic             acc;
  logic             gy;
  logic [2:0]       gstate;

  assign acc = (state_q == C_IDLE) && start;

  // Controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = C_RST;
      C_RST:   state_d = C_DRIVE;
      C_DRIVE: if (idx_q == CNT_W'(WIDTH - 1)) state_d = C_DRAIN;
      C_DRAIN: state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= C_IDLE;
    else        state_q <= state_d;
  end

  // Running mismatch count including the sample taken on this edge.
  always_comb begin
    cnt_d = cnt_q;
    if (smp_q && (y_in != gy)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Serializer, recognizer reset, capture and compare.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      x_q    <= 1'b0;
      drst_q <= 1'b0;
      idx_q  <= '0;
      smp_q  <= 1'b0;
      yw_q   <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      drst_q <= ~acc;
      smp_q  <= (state_q == C_DRIVE);
      x_q    <= 1'b0;
      if (acc) begin
        sh_q   <= pattern;
        idx_q  <= '0;
        yw_q   <= '0;
        cnt_q  <= '0;
        pass_q <= 1'b0;
      end
      if (state_q == C_RST || state_q == C_DRIVE) begin
        // zeros shift in behind the pattern, so the post-last bit is 0
        x_q  <= sh_q[WIDTH-1];
        sh_q <= sh_q << 1;
      end
      if (state_q == C_RST)   idx_q <= '0;
      if (state_q == C_DRIVE) idx_q <= idx_q + CNT_W'(1);
      if (smp_q) begin
        yw_q  <= {yw_q[WIDTH-2:0], y_in};
        cnt_q <= cnt_d;
      end
      if (state_q == C_DRAIN) pass_q <= (cnt_d == '0);
    end
  end

  fsm_golden_model u_gold (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (acc),
    .en_i    (state_q == C_DRIVE),
    .x_i     (x_q),
    .state_o (gstate),
    .y_o     (gy)
  );

  assign busy         = (state_q != C_IDLE);
  assign done         = (state_q == C_DONE);
  assign x_out        = x_q;
  assign dut_reset_n  = drst_q;
  assign y_word       = yw_q;
  assign mismatch_cnt = cnt_q;
  assign pass         = pass_q;
  assign model_state  = gstate;

endmodule
